ila_uart_dump: RTL

Downstream drain stage for the capture FIFO. Pops one DW-bit sample at a time using the FIFO's registered read port (`rd`/`dout`/`empty`), splits it into bytes, and transmits each byte as 8N1 UART on a single TX pin. Captured samples are streamed to the host at a fixed baud rate derived from the system clock.

---
 rtl/ila_uart_dump.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ila_uart_dump.sv
// Drains DW-bit samples from the capture FIFO and streams them out as 8N1 UART bytes,
// most-significant byte first, at CLKS_PER_BIT clocks per bit.
module ila_uart_dump #(
  parameter int unsigned DW           = 64,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          fifo_empty_i,
  input  logic [DW-1:0] fifo_dout_i,
  output logic          fifo_rd_o,
  output logic          uart_tx_o,
  output logic          busy_o,
  output logic [15:0]   word_cnt_o
);

  localparam int unsigned NBytes = DW / 8;
  localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned ByteW  = (NBytes > 1) ? $clog2(NBytes) : 1;

  typedef enum logic [2:0] {StIdle, StPop, StLatch, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [ByteW-1:0]  byte_idx_q, byte_idx_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic       baud_last, bit_last, byte_last;
  logic [7:0] cur_byte;

  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_idx_q == 3'd7);
  assign byte_last = (byte_idx_q == ByteW'(NBytes - 1));
  // The byte on the wire always sits in the top of the shift register.
  assign cur_byte  = shift_q[DW-1 -: 8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en_i && !fifo_empty_i) state_d = StPop;
      StPop:   state_d = StLatch;
      StLatch: state_d = StStart;
      StStart: if (baud_last) state_d = StData;
      StData:  if (baud_last && bit_last) state_d = StStop;
      StStop:  if (baud_last) state_d = byte_last ? StIdle : StStart;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_rd_o = 1'b0;
    uart_tx_o = 1'b1;
    busy_o    = (state_q != StIdle);
    case (state_q)
      StPop:   fifo_rd_o = 1'b1;
      StStart: uart_tx_o = 1'b0;
      StData:  uart_tx_o = cur_byte[bit_idx_q];
      default: ;
    endcase
  end

  always_comb begin
    baud_d     = '0;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      StLatch: begin
        shift_d    = fifo_dout_i;
        byte_idx_d = '0;
      end
      StStart: begin
        baud_d = baud_last ? '0 : baud_q + BaudW'(1);
        if (baud_last) bit_idx_d = '0;
      end
      StData: begin
        baud_d = baud_last ? '0 : baud_q + BaudW'(1);
        if (baud_last) bit_idx_d = bit_idx_q + 3'd1;
      end
      StStop: begin
        baud_d = baud_last ? '0 : baud_q + BaudW'(1);
        if (baud_last) begin
          if (byte_last) begin
            word_cnt_d = word_cnt_q + 16'd1;
          end else begin
            byte_idx_d = byte_idx_q + ByteW'(1);
            shift_d    = shift_q << 8;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;

endmodule
